// File: rtl/axi4_mgr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi4_mgr_arbiter                                                           |
// | Round-robin sharing of one axi4_mgr between NUM_REQ command requesters,    |
// | with independent write and read channels.                                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module axi4_mgr_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int DATA_COUNT_WIDTH = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic [NUM_REQ-1:0]                    cmd_valid_i,
  output logic [NUM_REQ-1:0]                    cmd_ready_o,
  input  logic [NUM_REQ-1:0]                    cmd_we_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]     cmd_addr_i,
  input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0]   cmd_count_i,
  output logic [NUM_REQ-1:0]                    done_o,
  output logic [NUM_REQ*2-1:0]                  err_o,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]     wr_data_i,
  output logic [NUM_REQ-1:0]                    wr_pop_o,
  output logic [AXI_DATA_WIDTH-1:0]             rd_data_o,
  output logic [NUM_REQ-1:0]                    rd_push_o,
  input  logic [NUM_REQ-1:0]                    rd_space_i,
  output logic [1:0]                            mgr_req_o,
  output logic [AXI_ADDR_WIDTH-1:0]             mgr_wr_addr_o,
  output logic [AXI_ADDR_WIDTH-1:0]             mgr_rd_addr_o,
  output logic [DATA_COUNT_WIDTH-1:0]           mgr_wr_count_o,
  output logic [DATA_COUNT_WIDTH-1:0]           mgr_rd_count_o,
  input  logic [1:0]                            mgr_rsp_i,
  input  logic [1:0]                            mgr_wr_err_i,
  input  logic [1:0]                            mgr_rd_err_i,
  input  logic                                  mgr_wr_fifo_req_i,
  output logic [AXI_DATA_WIDTH-1:0]             mgr_wr_fifo_data_o,
  output logic                                  mgr_rd_fifo_req_o,
  input  logic                                  mgr_rd_fifo_gnt_i,
  input  logic [AXI_DATA_WIDTH-1:0]             mgr_rd_fifo_data_i
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_ERR_W = 2 * NUM_REQ;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Channel 0 serves write commands, channel 1 serves read commands.
  logic [1:0][NUM_REQ-1:0] w_cand;
  assign w_cand[0] = cmd_valid_i & cmd_we_i;
  assign w_cand[1] = cmd_valid_i & ~cmd_we_i;

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    state_t                        r_state;
    logic [c_IDX_W-1:0]            r_ptr;
    logic [c_IDX_W-1:0]            r_owner;
    logic [AXI_ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_COUNT_WIDTH-1:0]   r_count;
    logic [1:0]                    r_err;
    logic [c_IDX_W-1:0]            w_sel;
    logic [c_IDX_W-1:0]            w_idx;
    logic                          w_found;
    logic                          w_active;
    logic [NUM_REQ-1:0]            w_ready;
    logic [NUM_REQ-1:0]            w_onehot;
    logic [NUM_REQ-1:0]            w_done_vec;
    logic [c_ERR_W-1:0]            w_err_vec;

    // First candidate at or after the pointer, wrapping around.
    always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = c_IDX_W'((int'(r_ptr) + k) % NUM_REQ);
        if (!w_found && w_cand[ch][w_idx]) begin
          w_found = 1'b1;
          w_sel   = w_idx;
        end
      end
    end

    assign w_ready    = (rstn_i && r_state == S_IDLE && w_found) ? (NUM_REQ'(1) << w_sel) : '0;
    assign w_active   = (r_state == S_ISSUE) || (r_state == S_BUSY);
    assign w_onehot   = NUM_REQ'(1) << r_owner;
    assign w_done_vec = (r_state == S_DONE) ? w_onehot : '0;
    assign w_err_vec  = (r_state == S_DONE) ? (c_ERR_W'(r_err) << (2 * int'(r_owner))) : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_state <= S_IDLE;
        r_ptr   <= '0;
        r_owner <= '0;
        r_addr  <= '0;
        r_count <= '0;
        r_err   <= 2'b00;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_found) begin
              r_owner <= w_sel;
              r_addr  <= cmd_addr_i[int'(w_sel)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
              r_count <= cmd_count_i[int'(w_sel)*DATA_COUNT_WIDTH +: DATA_COUNT_WIDTH];
              r_ptr   <= (int'(w_sel) == NUM_REQ - 1) ? '0 : w_sel + 1'b1;
              r_err   <= 2'b00;
              // Zero-beat commands complete without touching the manager.
              r_state <= (cmd_count_i[int'(w_sel)*DATA_COUNT_WIDTH +: DATA_COUNT_WIDTH] == '0)
                         ? S_DONE : S_ISSUE;
            end
          end
          S_ISSUE: r_state <= S_BUSY;
          S_BUSY: begin
            if (mgr_rsp_i[ch]) begin
              r_err   <= (ch == 0) ? mgr_wr_err_i : mgr_rd_err_i;
              r_state <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready_o    = g_chan[0].w_ready | g_chan[1].w_ready;
  assign done_o         = g_chan[0].w_done_vec | g_chan[1].w_done_vec;
  assign err_o          = g_chan[0].w_err_vec | g_chan[1].w_err_vec;
  assign mgr_req_o      = {g_chan[1].r_state == S_ISSUE, g_chan[0].r_state == S_ISSUE};
  assign mgr_wr_addr_o  = g_chan[0].r_addr;
  assign mgr_rd_addr_o  = g_chan[1].r_addr;
  assign mgr_wr_count_o = g_chan[0].r_count;
  assign mgr_rd_count_o = g_chan[1].r_count;

  // FIFO-side steering toward the owner while the channel is in flight.
  assign mgr_wr_fifo_data_o = g_chan[0].w_active
                              ? wr_data_i[int'(g_chan[0].r_owner)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
                              : '0;
  assign wr_pop_o           = (g_chan[0].w_active && mgr_wr_fifo_req_i) ? g_chan[0].w_onehot : '0;
  assign mgr_rd_fifo_req_o  = g_chan[1].w_active && rd_space_i[g_chan[1].r_owner];
  assign rd_push_o          = (g_chan[1].w_active && mgr_rd_fifo_gnt_i) ? g_chan[1].w_onehot : '0;
  assign rd_data_o          = g_chan[1].w_active ? mgr_rd_fifo_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi4_mgr_arbiter.sv
`default_nettype none
// Self-checking bench for axi4_mgr_arbiter: timestamp-based channel model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_axi4_mgr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NEVER = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rstn;
  logic [N-1:0]    cmd_valid, cmd_ready, cmd_we, done, wr_pop, rd_push, rd_space;
  logic [N*AW-1:0] cmd_addr;
  logic [N*CW-1:0] cmd_count;
  logic [2*N-1:0]  err;
  logic [N*DW-1:0] wr_data;
  logic [DW-1:0]   rd_data, mgr_wr_fifo_data, mgr_rd_fifo_data;
  logic [1:0]      mgr_req, mgr_rsp, mgr_wr_err, mgr_rd_err;
  logic [AW-1:0]   mgr_wr_addr, mgr_rd_addr;
  logic [CW-1:0]   mgr_wr_count, mgr_rd_count;
  logic            mgr_wr_fifo_req, mgr_rd_fifo_req, mgr_rd_fifo_gnt;

  axi4_mgr_arbiter #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .DATA_COUNT_WIDTH(CW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_count_i(cmd_count),
    .done_o(done), .err_o(err),
    .wr_data_i(wr_data), .wr_pop_o(wr_pop),
    .rd_data_o(rd_data), .rd_push_o(rd_push), .rd_space_i(rd_space),
    .mgr_req_o(mgr_req),
    .mgr_wr_addr_o(mgr_wr_addr), .mgr_rd_addr_o(mgr_rd_addr),
    .mgr_wr_count_o(mgr_wr_count), .mgr_rd_count_o(mgr_rd_count),
    .mgr_rsp_i(mgr_rsp), .mgr_wr_err_i(mgr_wr_err), .mgr_rd_err_i(mgr_rd_err),
    .mgr_wr_fifo_req_i(mgr_wr_fifo_req), .mgr_wr_fifo_data_o(mgr_wr_fifo_data),
    .mgr_rd_fifo_req_o(mgr_rd_fifo_req), .mgr_rd_fifo_gnt_i(mgr_rd_fifo_gnt),
    .mgr_rd_fifo_data_i(mgr_rd_fifo_data)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic [N-1:0] auto_rep;
  logic         gnt_off;
  int           rsp_delay [2];
  logic [1:0]   rsp_err_cfg [2];
  int           rsp_cnt [2];
  int           tk = 0;
  int           glog[$];

  logic [N-1:0]   s_ready, s_done, s_hs, s_push;
  logic [2*N-1:0] s_err;
  logic [1:0]     s_req;
  logic [AW-1:0]  s_wr_addr, s_rd_addr;
  logic           s_rdreq;

  // One clock: snapshot outputs at negedge, then drive next inputs after posedge.
  task automatic tick();
    @(negedge clk);
    s_ready = cmd_ready; s_done = done; s_err = err; s_req = mgr_req;
    s_wr_addr = mgr_wr_addr; s_rd_addr = mgr_rd_addr;
    s_rdreq = mgr_rd_fifo_req; s_push = rd_push;
    s_hs = cmd_valid & cmd_ready;
    @(posedge clk);
    #1;
    tk++;
    for (int i = 0; i < N; i++) begin
      if (s_hs[i]) begin
        glog.push_back(i);
        if (auto_rep[i]) cmd_addr[i*AW +: AW] = cmd_addr[i*AW +: AW] + 32'h100;
        else cmd_valid[i] = 1'b0;
      end
      wr_data[i*DW +: DW] = {32'hA5A5_0000 | 32'(i), 32'(tk)};
    end
    mgr_wr_fifo_req  = tk[0];
    mgr_rd_fifo_gnt  = tk[1] & ~gnt_off;
    mgr_rd_fifo_data = {$urandom, $urandom};
    for (int ch = 0; ch < 2; ch++) begin
      mgr_rsp[ch] = 1'b0;
      if (!rstn) rsp_cnt[ch] = 0;
      else begin
        if (rsp_cnt[ch] > 0) begin
          rsp_cnt[ch]--;
          if (rsp_cnt[ch] == 0) mgr_rsp[ch] = 1'b1;
        end
        if (mgr_req[ch]) rsp_cnt[ch] = rsp_delay[ch];
      end
    end
    mgr_wr_err = rsp_err_cfg[0];
    mgr_rd_err = rsp_err_cfg[1];
  endtask

  task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [CW-1:0] c);
    cmd_valid[i] = 1'b1;
    cmd_we[i] = we;
    cmd_addr[i*AW +: AW] = a;
    cmd_count[i*CW +: CW] = c;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    cmd_valid = '0;
    auto_rep = '0;
    tick();
    tick();
    check("reset_outputs", {s_ready, s_done, s_err, s_req, s_rdreq, s_push}, 64'd0);
    rstn = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (s_done == '0 && n < lim);
  endtask

  // ---------------- behavioural model and per-cycle compare ----------------
  int            m_own [2] = '{-1, -1};
  int            m_cnt [2], m_acc [2], m_rsp [2], m_done [2], m_ptr [2], g [2];
  logic [1:0]    m_err [2];
  logic [AW-1:0] m_addr [2];
  int            cyc = 0;
  logic [N-1:0]   e_ready, e_done, e_wpop, e_push, cand;
  logic [2*N-1:0] e_err;
  logic [1:0]     e_req;
  logic           e_rdreq, a_wr, a_rd;
  logic [DW-1:0]  e_wdata, e_rdata;

  always @(negedge clk) begin : cmp
    if (!rstn) begin
      check("rst_ctl", {cmd_ready, done, err, mgr_req, wr_pop, rd_push, mgr_rd_fifo_req}, 64'd0);
      check("rst_addr", {mgr_wr_addr, mgr_rd_addr}, 64'd0);
      check("rst_count", {mgr_wr_count, mgr_rd_count}, 64'd0);
      check("rst_wdata", mgr_wr_fifo_data, 64'd0);
      check("rst_rdata", rd_data, 64'd0);
      for (int ch = 0; ch < 2; ch++) begin
        m_own[ch] = -1; m_ptr[ch] = 0;
      end
    end else begin
      e_ready = '0; e_done = '0; e_err = '0; e_req = '0; e_wpop = '0; e_push = '0;
      e_rdreq = 1'b0; e_wdata = '0; e_rdata = '0; a_wr = 1'b0; a_rd = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        cand = (ch == 0) ? (cmd_valid & cmd_we) : (cmd_valid & ~cmd_we);
        g[ch] = -1;
        if (m_own[ch] < 0) begin
          for (int k = 0; k < N; k++)
            if (g[ch] < 0 && cand[(m_ptr[ch] + k) % N]) g[ch] = (m_ptr[ch] + k) % N;
          if (g[ch] >= 0) e_ready[g[ch]] = 1'b1;
        end else begin
          if (m_cnt[ch] > 0 && cyc > m_acc[ch] && (m_rsp[ch] < 0 || cyc <= m_rsp[ch])) begin
            if (ch == 0) a_wr = 1'b1; else a_rd = 1'b1;
          end
          if (m_cnt[ch] > 0 && cyc == m_acc[ch] + 1) e_req[ch] = 1'b1;
          if (cyc == m_done[ch]) begin
            e_done[m_own[ch]] = 1'b1;
            e_err[2*m_own[ch] +: 2] = e_err[2*m_own[ch] +: 2] | m_err[ch];
          end
        end
      end
      if (a_wr) begin
        e_wdata = wr_data[m_own[0]*DW +: DW];
        if (mgr_wr_fifo_req) e_wpop[m_own[0]] = 1'b1;
        check("wr_addr", mgr_wr_addr, m_addr[0]);
        check("wr_count", mgr_wr_count, 64'(m_cnt[0]));
      end
      if (a_rd) begin
        e_rdreq = rd_space[m_own[1]];
        if (mgr_rd_fifo_gnt) e_push[m_own[1]] = 1'b1;
        e_rdata = mgr_rd_fifo_data;
        check("rd_addr", mgr_rd_addr, m_addr[1]);
        check("rd_count", mgr_rd_count, 64'(m_cnt[1]));
      end
      check("cmd_ready", cmd_ready, e_ready);
      check("done", done, e_done);
      check("err", err, e_err);
      check("mgr_req", mgr_req, e_req);
      check("wr_pop", wr_pop, e_wpop);
      check("wr_fifo_data", mgr_wr_fifo_data, e_wdata);
      check("rd_fifo_req", mgr_rd_fifo_req, e_rdreq);
      check("rd_push", rd_push, e_push);
      check("rd_data", rd_data, e_rdata);
      // Advance the model to what the coming edge must do.
      for (int ch = 0; ch < 2; ch++) begin
        if (m_own[ch] >= 0) begin
          if (m_cnt[ch] > 0 && m_rsp[ch] < 0 && cyc >= m_acc[ch] + 2 && mgr_rsp[ch]) begin
            m_rsp[ch] = cyc;
            m_err[ch] = (ch == 0) ? mgr_wr_err : mgr_rd_err;
            m_done[ch] = cyc + 1;
          end else if (cyc == m_done[ch]) begin
            m_own[ch] = -1;
          end
        end else if (g[ch] >= 0) begin
          m_own[ch]  = g[ch];
          m_acc[ch]  = cyc;
          m_cnt[ch]  = int'(cmd_count[g[ch]*CW +: CW]);
          m_addr[ch] = cmd_addr[g[ch]*AW +: AW];
          m_ptr[ch]  = (g[ch] + 1) % N;
          m_rsp[ch]  = -1;
          m_err[ch]  = 2'b00;
          m_done[ch] = (m_cnt[ch] == 0) ? cyc + 1 : NEVER;
        end
      end
    end
    cyc++;
  end

  // ---------------- directed scenarios ----------------
  int exp_order [5] = '{0, 1, 2, 3, 0};
  int n, np;
  logic [N-1:0] dacc;

  initial begin
    rstn = 1'b0; cmd_valid = '0; cmd_we = '0; cmd_addr = '0; cmd_count = '0; wr_data = '0;
    rd_space = '1; mgr_rsp = '0; mgr_wr_err = '0; mgr_rd_err = '0; mgr_wr_fifo_req = 1'b0;
    mgr_rd_fifo_gnt = 1'b0; mgr_rd_fifo_data = '0; auto_rep = '0; gnt_off = 1'b0;
    rsp_delay = '{8, 8}; rsp_err_cfg = '{2'b00, 2'b00}; rsp_cnt = '{0, 0};

    // Single write from requester 1.
    apply_reset();
    set_cmd(1, 1'b1, 32'h1000, 8'd4);
    tick(); check("t1_accept", s_hs, 4'b0010);
    tick(); check("t1_req", s_req, 2'b01); check("t1_addr", s_wr_addr, 32'h1000);
    tick(); check("t1_req_once", s_req, 2'b00);
    wait_done(40, n);
    check("t1_done", s_done, 4'b0010);
    check("t1_err", s_err, 8'h00);
    check("t1_latency", n, 8);

    // Round-robin across four continuous writers.
    apply_reset();
    rsp_delay[0] = 2;
    auto_rep = '1;
    for (int i = 0; i < N; i++) set_cmd(i, 1'b1, 32'h8000 + 32'(i) * 32'h1_0000, 8'd2);
    glog.delete();
    n = 0;
    while (glog.size() < 5 && n < 200) begin tick(); n++; end
    check("t2_grants", glog.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < glog.size(); i++) check("t2_order", glog[i], exp_order[i]);
    auto_rep = '0;
    cmd_valid = '0;

    // Concurrent read (req0) and write (req2).
    apply_reset();
    rsp_delay = '{3, 6};
    set_cmd(0, 1'b0, 32'h2000, 8'd8);
    set_cmd(2, 1'b1, 32'h3000, 8'd2);
    tick(); check("t3_accept", s_hs, 4'b0101);
    tick(); check("t3_req", s_req, 2'b11);
    dacc = '0; np = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      dacc = dacc | s_done;
      if (s_done != '0) np++;
    end
    check("t3_done_set", dacc, 4'b0101);
    check("t3_pulses", np, 2);

    // Read error code returned with done.
    apply_reset();
    rsp_delay[1] = 4;
    rsp_err_cfg[1] = 2'b10;
    set_cmd(2, 1'b0, 32'h4000, 8'd3);
    wait_done(40, n);
    check("t4_done", s_done, 4'b0100);
    check("t4_err", s_err, 8'b0010_0000);
    tick();
    check("t4_err_clear", s_err, 8'h00);
    check("t4_done_clear", s_done, 4'b0000);
    rsp_err_cfg[1] = 2'b00;

    // Zero-count write completes without a manager request.
    apply_reset();
    set_cmd(3, 1'b1, 32'h5000, 8'd0);
    tick(); check("t5_accept", s_hs, 4'b1000);
    tick(); check("t5_done", s_done, 4'b1000); check("t5_no_req", s_req, 2'b00);
    tick(); check("t5_done_clear", s_done, 4'b0000); check("t5_no_req2", s_req, 2'b00);

    // Read steering with a full FIFO, then reset while busy.
    apply_reset();
    rd_space = 4'b1101;
    gnt_off = 1'b1;
    rsp_delay[1] = 30;
    set_cmd(1, 1'b0, 32'h6000, 8'd4);
    tick(); check("t6_accept", s_hs, 4'b0010);
    tick(); check("t6_req", s_req, 2'b10); check("t6_rdreq", s_rdreq, 1'b0); check("t6_push", s_push, 4'b0000);
    tick(); check("t6_rdreq_busy", s_rdreq, 1'b0); check("t6_rd_addr", s_rd_addr, 32'h6000);
    rstn = 1'b0;
    tick();
    check("t6_reset_outs", {s_req, s_rdreq, s_push, s_done, s_err, s_ready}, 64'd0);
    check("t6_reset_addr", s_rd_addr, 32'h0);
    rstn = 1'b1;
    gnt_off = 1'b0;
    rd_space = '1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
